// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, transmitter FSM states and a frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Clocks occupied by one complete frame on the line.
  function automatic int frame_clocks(input int dvsr, input int word_size,
                                      input int parity, input int stop_bits);
    return dvsr * (1 + word_size + ((parity != 0) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write port of the UART transmitter: word + strobe in, full/level/overflow status back.
interface uart_tx_fifo_if #(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [WORD_SIZE-1:0]          dataBus;
  logic                          wrEn;
  logic                          full;
  logic [$clog2(FIFO_DEPTH):0]   fifoLevel;
  logic                          overflow;

  modport master (output dataBus, output wrEn, input full, input fifoLevel, input overflow);
  modport slave  (input dataBus, input wrEn, output full, output fifoLevel, output overflow);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, data visible on pop_dat the cycle after push; pushes when full
// and pops when empty are ignored, so callers may strobe freely.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued UART transmitter: write -> start bit falls 2 cycles later, frames sent back-to-back;
// writes while full are dropped with an overflow pulse. UART_TX_BREAK_EN adds the sendBreak port.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DVSR       = 347,
  parameter int WORD_SIZE  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fifo_if.slave     wr,
`ifdef UART_TX_BREAK_EN
  input  logic              sendBreak,
`endif
  output logic              txBusy,
  output logic              txDone,
  output logic              serialOut
);
  localparam int      CW       = $clog2(DVSR);
  localparam int      BW       = $clog2(WORD_SIZE);
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  tx_state_e            state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [WORD_SIZE-1:0] shreg;
  logic                 par_bit;
  logic [WORD_SIZE-1:0] fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 bit_end;
  logic                 last_stop;
  logic                 brk_req;
  logic                 brk_q;

`ifdef UART_TX_BREAK_EN
  assign brk_req = sendBreak;

  // Remembers that the line was held in break so release gets one high cycle first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) brk_q <= 1'b0;
    else     brk_q <= (state == IDLE) && sendBreak;
  end
`else
  assign brk_req = 1'b0;
  assign brk_q   = 1'b0;
`endif

  assign fifo_push = wr.wrEn && !fifo_full;
  assign wr.full   = fifo_full;

  uart_sync_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (wr.dataBus),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (wr.fifoLevel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr.overflow <= 1'b0;
    else     wr.overflow <= wr.wrEn && fifo_full;
  end

  assign bit_end   = (baud_cnt == CW'(DVSR - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty && !brk_req) begin
      case (state)
        IDLE:    fifo_pop = !brk_q;
        STOP:    fifo_pop = bit_end && last_stop;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  // The state literal is package-qualified because the PARITY parameter shadows it here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      serialOut <= 1'b1;
      txBusy    <= 1'b0;
      txDone    <= 1'b0;
    end else begin
      txDone <= (state == STOP) && last_stop && (baud_cnt == CW'(DVSR - 2));
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (brk_req) begin
            serialOut <= 1'b0;
            txBusy    <= 1'b1;
          end else if (fifo_pop) begin
            state     <= START;
            shreg     <= fifo_dat;
            par_bit   <= (^fifo_dat) ^ (PAR_MODE == PAR_ODD);
            serialOut <= 1'b0;
            txBusy    <= 1'b1;
          end else begin
            serialOut <= 1'b1;
            txBusy    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            bit_idx   <= '0;
            serialOut <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BW'(WORD_SIZE - 1)) begin
              if (PAR_MODE != PAR_NONE) begin
                state     <= uart_pkg::PARITY;
                serialOut <= par_bit;
              end else begin
                state     <= STOP;
                stop_idx  <= 1'b0;
                serialOut <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + BW'(1);
              shreg     <= shreg >> 1;
              serialOut <= shreg[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            stop_idx  <= 1'b0;
            serialOut <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else if (fifo_pop) begin
              state     <= START;
              shreg     <= fifo_dat;
              par_bit   <= (^fifo_dat) ^ (PAR_MODE == PAR_ODD);
              serialOut <= 1'b0;
            end else begin
              state  <= IDLE;
              txBusy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DVSR=4, 8 data bits, 1 stop bit, depth 4; parity variants run alongside.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic brk = 1'b0;
  logic m_ser, m_busy, m_done;
  logic e_ser, e_busy, e_done;
  logic o_ser, o_busy, o_done;

  int n_chk = 0;
  int n_err = 0;
  int n_rst = 0;
  bit mon_en = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic cap_ser  [3][128];
  logic cap_busy [3][128];
  logic cap_done [3][128];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.WORD_SIZE(8), .FIFO_DEPTH(4)) m_if ();
  uart_tx_fifo_if #(.WORD_SIZE(8), .FIFO_DEPTH(4)) e_if ();
  uart_tx_fifo_if #(.WORD_SIZE(8), .FIFO_DEPTH(4)) o_if ();

  uart_tx_fifo #(.DVSR(4), .WORD_SIZE(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .wr(m_if),
`ifdef UART_TX_BREAK_EN
    .sendBreak(brk),
`endif
    .txBusy(m_busy), .txDone(m_done), .serialOut(m_ser));

  uart_tx_fifo #(.DVSR(4), .WORD_SIZE(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_even (
    .clk(clk), .rst(rst), .wr(e_if),
`ifdef UART_TX_BREAK_EN
    .sendBreak(1'b0),
`endif
    .txBusy(e_busy), .txDone(e_done), .serialOut(e_ser));

  uart_tx_fifo #(.DVSR(4), .WORD_SIZE(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_odd (
    .clk(clk), .rst(rst), .wr(o_if),
`ifdef UART_TX_BREAK_EN
    .sendBreak(1'b0),
`endif
    .txBusy(o_busy), .txDone(o_done), .serialOut(o_ser));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_ser[0][i] = m_ser;  cap_busy[0][i] = m_busy; cap_done[0][i] = m_done;
      cap_ser[1][i] = e_ser;  cap_busy[1][i] = e_busy; cap_done[1][i] = e_done;
      cap_ser[2][i] = o_ser;  cap_busy[2][i] = o_busy; cap_done[2][i] = o_done;
    end
  endtask

  function automatic logic [3:0] nib(input int d, input int b);
    return {cap_ser[d][4*b], cap_ser[d][4*b+1], cap_ser[d][4*b+2], cap_ser[d][4*b+3]};
  endfunction

  function automatic int first_done(input int d, input int n);
    for (int i = 0; i < n; i++) if (cap_done[d][i]) return i;
    return -1;
  endfunction

  function automatic int cnt_done(input int d, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_done[d][i]) c++;
    return c;
  endfunction

  function automatic int cnt_busy(input int d, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_busy[d][i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD;
  endfunction

  always @(posedge rst) n_rst++;

  // Line decoder for the PARITY=0 instance: samples each bit two clocks into its period.
  always begin
    @(negedge clk);
    if (mon_en && !rst && m_ser === 1'b0) begin
      int rst_mark;
      rst_mark = n_rst;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        rx_b[i] = m_ser;
      end
      repeat (4) @(negedge clk);
      if (rst_mark == n_rst) begin
        rx_q.push_back(rx_b);
        chk("rx stop bit", {31'h0, m_ser}, 32'h1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  f_none;
    logic [10:0] f_even;
    logic [10:0] f_odd;
    int t;
    int lows;
    int dones;
    f_none = 10'b1101010110;
    f_even = 11'b11101010110;
    f_odd  = 11'b10101010110;
    m_if.wrEn = 1'b0; m_if.dataBus = '0;
    e_if.wrEn = 1'b0; e_if.dataBus = '0;
    o_if.wrEn = 1'b0; o_if.dataBus = '0;

    repeat (3) @(negedge clk);
    chk("rst serialOut", {31'h0, m_ser}, 32'h1);
    chk("rst txBusy", {31'h0, m_busy}, 32'h0);
    chk("rst txDone", {31'h0, m_done}, 32'h0);
    chk("rst full", {31'h0, m_if.full}, 32'h0);
    chk("rst fifoLevel", {29'h0, m_if.fifoLevel}, 32'h0);
    chk("rst overflow", {31'h0, m_if.overflow}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Single 0xAB frame on all three parity variants
    #1;
    m_if.wrEn = 1'b1; m_if.dataBus = 8'hAB;
    e_if.wrEn = 1'b1; e_if.dataBus = 8'hAB;
    o_if.wrEn = 1'b1; o_if.dataBus = 8'hAB;
    @(posedge clk); #1;
    m_if.wrEn = 1'b0; e_if.wrEn = 1'b0; o_if.wrEn = 1'b0;
    m_if.dataBus = 8'h00;
    @(negedge clk);
    chk("t1 level after write", {29'h0, m_if.fifoLevel}, 32'h1);
    chk("t1 line idle before start", {31'h0, m_ser}, 32'h1);
    capture(48);
    for (int b = 0; b < 10; b++) chk($sformatf("t1 none bit%0d", b), {28'h0, nib(0, b)}, {28'h0, {4{f_none[b]}}});
    chk("t1 none idle after", {28'h0, nib(0, 10)}, 32'hF);
    chk("t1 none txDone index", first_done(0, 48), 39);
    chk("t1 none txDone count", cnt_done(0, 48), 1);
    chk("t1 none txBusy clocks", cnt_busy(0, 48), 40);
    chk("t1 none txBusy first", {31'h0, cap_busy[0][0]}, 32'h1);
    for (int b = 0; b < 11; b++) begin
      chk($sformatf("t1 even bit%0d", b), {28'h0, nib(1, b)}, {28'h0, {4{f_even[b]}}});
      chk($sformatf("t1 odd bit%0d", b), {28'h0, nib(2, b)}, {28'h0, {4{f_odd[b]}}});
    end
    chk("t1 even txDone index", first_done(1, 48), 43);
    chk("t1 odd txDone index", first_done(2, 48), 43);
    chk("t1 even txBusy clocks", cnt_busy(1, 48), 44);
    chk("t1 odd txBusy clocks", cnt_busy(2, 48), 44);
    chk("t1 rx count", rx_q.size(), 1);
    chk("t1 rx word", rx_at(0), 32'hAB);

    // Five writes fill past depth thanks to the first pop; the sixth overflows
    repeat (4) @(posedge clk);
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 m_if.wrEn = 1'b1; m_if.dataBus = 8'(i + 1);
      @(negedge clk);
      if (i == 4) chk("t2 not full on 5th", {31'h0, m_if.full}, 32'h0);
      if (i == 5) begin
        chk("t2 full on 6th", {31'h0, m_if.full}, 32'h1);
        chk("t2 level on 6th", {29'h0, m_if.fifoLevel}, 32'h4);
        chk("t2 no early overflow", {31'h0, m_if.overflow}, 32'h0);
      end
    end
    @(posedge clk); #1 m_if.wrEn = 1'b0; m_if.dataBus = 8'h00;
    @(negedge clk);
    chk("t2 overflow pulse", {31'h0, m_if.overflow}, 32'h1);
    @(negedge clk);
    chk("t2 overflow single", {31'h0, m_if.overflow}, 32'h0);
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!m_busy) break;
    end
    chk("t2 drain in time", {31'h0, (t < 400)}, 32'h1);
    chk("t2 rx count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2 rx word%0d", i), rx_at(i), i + 1);

    // Back-to-back 0x55, 0xAA
    repeat (4) @(posedge clk);
    rx_q.delete();
    @(posedge clk); #1 m_if.wrEn = 1'b1; m_if.dataBus = 8'h55;
    @(posedge clk); #1 m_if.dataBus = 8'hAA;
    @(posedge clk); #1 m_if.wrEn = 1'b0; m_if.dataBus = 8'h00;
    capture(88);
    chk("t3 first start", {31'h0, cap_ser[0][0]}, 32'h0);
    chk("t3 stop before 2nd", {31'h0, cap_ser[0][39]}, 32'h1);
    chk("t3 2nd start no gap", {31'h0, cap_ser[0][40]}, 32'h0);
    chk("t3 txDone first", first_done(0, 88), 39);
    chk("t3 txDone second", {31'h0, cap_done[0][79]}, 32'h1);
    chk("t3 txDone count", cnt_done(0, 88), 2);
    chk("t3 txBusy clocks", cnt_busy(0, 88), 80);
    chk("t3 rx count", rx_q.size(), 2);
    chk("t3 rx word0", rx_at(0), 32'h55);
    chk("t3 rx word1", rx_at(1), 32'hAA);

    // Reset during bit 4 of 0x0F with two words queued
    repeat (4) @(posedge clk);
    rx_q.delete();
    @(posedge clk); #1 m_if.wrEn = 1'b1; m_if.dataBus = 8'h0F;
    @(posedge clk); #1 m_if.dataBus = 8'h11;
    @(posedge clk); #1 m_if.dataBus = 8'h22;
    @(posedge clk); #1 m_if.wrEn = 1'b0; m_if.dataBus = 8'h00;
    repeat (20) @(posedge clk);
    #2;
    chk("t4 line low in bit4", {31'h0, m_ser}, 32'h0);
    chk("t4 level before rst", {29'h0, m_if.fifoLevel}, 32'h2);
    rst = 1'b1;
    #1;
    chk("t4 line high on rst", {31'h0, m_ser}, 32'h1);
    chk("t4 level on rst", {29'h0, m_if.fifoLevel}, 32'h0);
    chk("t4 busy on rst", {31'h0, m_busy}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    lows = 0; dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!m_ser) lows++;
      if (m_done) dones++;
    end
    chk("t4 line idle after rst", lows, 0);
    chk("t4 no txDone", dones, 0);
    chk("t4 level after rst", {29'h0, m_if.fifoLevel}, 32'h0);
    chk("t4 rx nothing", rx_q.size(), 0);

`ifdef UART_TX_BREAK_EN
    // Break held 100 clocks with 0x12 queued, then released
    mon_en = 1'b0;
    rx_q.delete();
    @(posedge clk); #1 brk = 1'b1; m_if.wrEn = 1'b1; m_if.dataBus = 8'h12;
    @(posedge clk); #1 m_if.wrEn = 1'b0; m_if.dataBus = 8'h00;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!m_ser) lows++;
      if (i == 0) chk("t5 busy in break", {31'h0, m_busy}, 32'h1);
      if (i == 99) chk("t5 pop inhibited", {29'h0, m_if.fifoLevel}, 32'h1);
    end
    brk = 1'b0;
    chk("t5 break low clocks", lows, 100);
    @(negedge clk);
    chk("t5 high after release", {31'h0, m_ser}, 32'h1);
    mon_en = 1'b1;
    @(negedge clk);
    chk("t5 start after release", {31'h0, m_ser}, 32'h0);
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!m_busy) break;
    end
    chk("t5 frame done in time", {31'h0, (t < 100)}, 32'h1);
    chk("t5 rx count", rx_q.size(), 1);
    chk("t5 rx word", rx_at(0), 32'h12);
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
